// File: rtl/rng_share_arbiter_if.sv
// Requester/generator-side bundle for rng_share_arbiter.
// The arbiter uses the slave modport; the environment drives through master.
interface rng_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned WIDTH   = 8
) ();
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               rsp_valid;
    logic [WIDTH-1:0]   rsp_data;
    logic               rng_en;
    logic [WIDTH-1:0]   rng_value;
    logic [15:0]        draw_count;

    modport master (
        output req, rng_value,
        input  grant, busy, rsp_valid, rsp_data, rng_en, draw_count
    );

    modport slave (
        input  req, rng_value,
        output grant, busy, rsp_valid, rsp_data, rng_en, draw_count
    );
endinterface

// File: rtl/rng_share_arbiter.sv
// Round-robin sharing of one random number generator between NUM_REQ requesters.
// Optional macro RNG_IDLE_SPIN_EN keeps the generator running while idle.
module rng_share_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    rng_share_arbiter_if.slave  bus
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef RNG_IDLE_SPIN_EN
    localparam logic IdleSpin = 1'b1;
`else
    localparam logic IdleSpin = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StAdvance, StCapture, StRespond} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               rng_en_q, rng_en_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;
    logic [15:0]        draw_cnt_q, draw_cnt_d;

    logic               sel_found;
    logic [IdxW-1:0]    sel_idx;
    logic [IdxW:0]      cand;

    // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NUM_REQ)) cand = cand - (IdxW+1)'(NUM_REQ);
            if (!sel_found && bus.req[cand[IdxW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        rng_en_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        draw_cnt_d  = draw_cnt_q;
        unique case (state_q)
            StIdle: begin
                rng_en_d = IdleSpin;
                if (sel_found) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    idx_d            = sel_idx;
                    cnt_d            = 8'(STEP_CYCLES - 1);
                    rng_en_d         = 1'b1;
                    state_d          = StAdvance;
                end
            end
            StAdvance: begin
                if (cnt_q == 8'd0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d    = cnt_q - 8'd1;
                    rng_en_d = 1'b1;
                end
            end
            StCapture: begin
                rsp_data_d  = bus.rng_value;
                rsp_valid_d = 1'b1;
                state_d     = StRespond;
            end
            StRespond: begin
                grant_d    = '0;
                rr_ptr_d   = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + IdxW'(1);
                draw_cnt_d = (draw_cnt_q == 16'hFFFF) ? draw_cnt_q : draw_cnt_q + 16'd1;
                rng_en_d   = IdleSpin;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= 8'd0;
            rng_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            draw_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            rng_en_q    <= rng_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            draw_cnt_q  <= draw_cnt_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rng_en     = rng_en_q;
    assign bus.draw_count = draw_cnt_q;
endmodule

// File: tb/tb_rng_share_arbiter.sv
// Scoreboard bench for rng_share_arbiter driving an 8-bit LFSR generator model.
// Expected draws are queued by the stimulus and checked by a separate monitor.
module tb_rng_share_arbiter;
`ifdef RNG_IDLE_SPIN_EN
    localparam int SPIN = 1;
`else
    localparam int SPIN = 0;
`endif

    typedef struct packed {
        logic [2:0] g;
        logic [7:0] d;
    } exp_t;

    logic clk;
    logic reset_n;
    logic armed;
    logic [7:0] lfsr;
    int n_tests;
    int n_fail;
    exp_t sb_q[$];

    rng_share_arbiter_if #(.NUM_REQ(3), .WIDTH(8)) bus ();

    rng_share_arbiter #(.NUM_REQ(3), .WIDTH(8), .STEP_CYCLES(4)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < n; i++) v = lfsr_next(v);
        return v;
    endfunction

    // k-th draw after reset, one idle cycle between back-to-back draws.
    function automatic logic [7:0] exp_data(input int k);
        return lfsr_after(4 * k + (k - 1) * SPIN);
    endfunction

    // Generator model: reseeds with the arbiter reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr <= 8'h01;
        else if (bus.rng_en) lfsr <= lfsr_next(lfsr);
    end
    assign bus.rng_value = lfsr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: grant/busy consistency every cycle, scoreboard pop on rsp_valid.
    always @(negedge clk) begin
        exp_t e;
        if (armed && reset_n) begin
            check("grant_vs_busy",
                  bus.busy ? 32'($countones(bus.grant) == 1) : 32'(bus.grant == 3'b000), 1);
            if (bus.rsp_valid) begin
                check("rng_en_in_respond", bus.rng_en, 0);
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got grant %b data %h, expected none",
                             bus.grant, bus.rsp_data);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_grant", bus.grant, e.g);
                    check("rsp_data", bus.rsp_data, e.d);
                end
            end
        end
    end

    // Called at a falling edge; asserts reset, checks zero outputs, releases.
    task automatic do_reset();
        reset_n = 1'b0;
        bus.req = '0;
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rng_en", bus.rng_en, 0);
        check("rst_draw_count", bus.draw_count, 0);
        @(negedge clk);
        @(negedge clk);
        check("sb_empty_at_reset", sb_q.size(), 0);
        sb_q.delete();
        reset_n = 1'b1;
        armed   = 1'b1;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.rsp_valid && cycles < 40);
        if (!bus.rsp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid, expected within 40 cycles");
        end
    endtask

    task automatic run_draw(input logic [2:0] r, input logic [2:0] g, input logic [7:0] d);
        int c;
        sb_q.push_back('{g: g, d: d});
        bus.req = r;
        wait_rsp(c);
        bus.req = '0;
        @(negedge clk);
    endtask

    initial begin
        int c;
        int en;
        n_tests = 0;
        n_fail  = 0;
        armed   = 1'b0;
        reset_n = 1'b1;
        bus.req = '0;
        @(negedge clk);

        // Single draw: latency, enable window, captured value, count.
        do_reset();
        sb_q.push_back('{g: 3'b001, d: exp_data(1)});
        bus.req = 3'b001;
        @(negedge clk);
        check("t1_grant", bus.grant, 3'b001);
        check("t1_busy", bus.busy, 1);
        en = bus.rng_en;
        c  = 0;
        do begin
            @(negedge clk);
            c++;
            if (!bus.rsp_valid) en += bus.rng_en;
        end while (!bus.rsp_valid && c < 40);
        check("t1_latency", c, 5);
        check("t1_rng_en_cycles", en, 4);
        bus.req = '0;
        @(negedge clk);
        check("t1_grant_idle", bus.grant, 0);
        check("t1_busy_idle", bus.busy, 0);
        check("t1_draw_count", bus.draw_count, 1);
        check("t1_rsp_data_hold", bus.rsp_data, 8'h11);

        // All requesters pending: round-robin order, 7-cycle spacing.
        do_reset();
        sb_q.push_back('{g: 3'b001, d: exp_data(1)});
        sb_q.push_back('{g: 3'b010, d: exp_data(2)});
        sb_q.push_back('{g: 3'b100, d: exp_data(3)});
        sb_q.push_back('{g: 3'b001, d: exp_data(4)});
        bus.req = 3'b111;
        wait_rsp(c);
        check("t2_first_latency", c, 6);
        for (int k = 2; k <= 4; k++) begin
            wait_rsp(c);
            check("t2_spacing", c, 7);
        end
        bus.req = '0;
        @(negedge clk);
        check("t2_draw_count", bus.draw_count, 4);

        // Requester 2 drops mid-draw; the draw completes and rr_ptr wraps to 0.
        do_reset();
        sb_q.push_back('{g: 3'b100, d: exp_data(1)});
        bus.req = 3'b100;
        @(negedge clk);
        check("t3_grant", bus.grant, 3'b100);
        @(negedge clk);
        bus.req = '0;
        wait_rsp(c);
        @(negedge clk);
        check("t3_draw_count", bus.draw_count, 1);
        run_draw(3'b101, 3'b001, exp_data(2));

        // Reset during CAPTURE aborts without a response.
        do_reset();
        bus.req = 3'b010;
        repeat (5) @(negedge clk);
        check("t4_busy_capture", bus.busy, 1);
        check("t4_rng_en_capture", bus.rng_en, 0);
        do_reset();
        run_draw(3'b011, 3'b001, exp_data(1));
        run_draw(3'b010, 3'b010, exp_data(2));
        check("t4_draw_count", bus.draw_count, 2);

        // Ten idle cycles before a request: generator spins only with the macro.
        do_reset();
        en = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en += bus.rng_en;
        end
        check("t5_idle_rng_en", en, 10 * SPIN);
        run_draw(3'b010, 3'b010, lfsr_after(SPIN != 0 ? 14 : 4));

        // Saturating draw counter.
        do_reset();
        force dut.draw_cnt_q = 16'hFFFD;
        @(negedge clk);
        release dut.draw_cnt_q;
        check("t6_preset", bus.draw_count, 16'hFFFD);
        run_draw(3'b001, 3'b001, exp_data(1));
        check("t6_count_1", bus.draw_count, 16'hFFFE);
        run_draw(3'b001, 3'b001, exp_data(2));
        check("t6_count_2", bus.draw_count, 16'hFFFF);
        run_draw(3'b001, 3'b001, exp_data(3));
        check("t6_count_3", bus.draw_count, 16'hFFFF);

        @(negedge clk);
        check("sb_empty_at_end", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1);
    end
endmodule
